// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_INC  = 4;
  localparam int PC8_OFS = 8;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fb_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : One-entry fetch buffer; clear beats load, load beats drain.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] loadInstr,
  input  logic [WIDTH-1:0] loadPc,
  output logic             valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc
);

  logic             r_valid;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_pc;

  // Load beats drain so a consumed entry can be refilled on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_instr <= loadInstr;
      r_pc    <= loadPc;
    end else if (drain) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign instr = r_instr;
  assign pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : ARM pipeline fetch: PCF, req/ack instruction fetch, 1-entry FB,
//            F/D register. Optional counters under FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             BranchTakenE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic             PCSrcW,
  input  logic [WIDTH-1:0] ResultW,
  output logic             IReqF,
  output logic [WIDTH-1:0] IAddrF,
  input  logic             IAckF,
  input  logic [WIDTH-1:0] IRdataF,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCPlus8D,
  output logic             ValidD,
  output logic             FetchBusyF,
  output logic [31:0]      FetchCntF,
  output logic [31:0]      DropCntF
);

  fetch_state_t     r_state;
  logic [WIDTH-1:0] r_pcF;
  logic [WIDTH-1:0] r_reqAddr;
  logic [WIDTH-1:0] r_instrD;
  logic [WIDTH-1:0] r_pcPlus8D;
  logic             r_validD;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic             w_iReq;
  logic             w_load;
  logic             w_drain;
  logic             w_fbValid;
  logic [WIDTH-1:0] w_fbInstr;
  logic [WIDTH-1:0] w_fbPc;

  assign w_redirect = BranchTakenE | PCSrcW;
  assign w_target   = BranchTakenE ? ALUResultE : ResultW;

  always_comb begin
    w_iReq = 1'b0;
    case (r_state)
      REQ:     w_iReq = ~StallF & ~w_redirect & (~w_fbValid | ~StallD);
      WAIT,
      DROP:    w_iReq = 1'b1;
      default: w_iReq = 1'b0;
    endcase
    // Reset is asynchronous, so the request must drop without waiting for an edge.
    if (reset) w_iReq = 1'b0;
  end

  assign IReqF      = w_iReq;
  assign IAddrF     = (r_state == REQ) ? r_pcF : r_reqAddr;
  assign FetchBusyF = (r_state != REQ);

  assign w_load  = w_iReq & IAckF & (r_state != DROP) & ~w_redirect;
  assign w_drain = ~FlushD & ~StallD & w_fbValid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= REQ;
      r_pcF     <= WIDTH'(RESET_PC);
      r_reqAddr <= WIDTH'(RESET_PC);
    end else begin
      case (r_state)
        REQ: begin
          if (w_redirect) begin
            r_pcF <= w_target;
          end else if (w_iReq) begin
            if (IAckF) begin
              r_pcF <= r_pcF + WIDTH'(PC_INC);
            end else begin
              r_state   <= WAIT;
              r_reqAddr <= r_pcF;
            end
          end
        end
        WAIT: begin
          if (IAckF) begin
            r_state <= REQ;
            r_pcF   <= w_redirect ? w_target : r_pcF + WIDTH'(PC_INC);
          end else if (w_redirect) begin
            r_state <= DROP;
            r_pcF   <= w_target;
          end
        end
        DROP: begin
          // The outstanding access still has to complete; its data is thrown away.
          if (w_redirect) r_pcF <= w_target;
          if (IAckF) r_state <= REQ;
        end
        default: r_state <= REQ;
      endcase
    end
  end

  fetch_buffer #(
    .WIDTH (WIDTH)
  ) u_fetchBuffer (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_redirect),
    .load      (w_load),
    .drain     (w_drain),
    .loadInstr (IRdataF),
    .loadPc    (IAddrF),
    .valid     (w_fbValid),
    .instr     (w_fbInstr),
    .pc        (w_fbPc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instrD   <= '0;
      r_pcPlus8D <= '0;
      r_validD   <= 1'b0;
    end else if (FlushD) begin
      r_instrD   <= '0;
      r_pcPlus8D <= '0;
      r_validD   <= 1'b0;
    end else if (!StallD) begin
      if (w_fbValid) begin
        r_instrD   <= w_fbInstr;
        r_pcPlus8D <= w_fbPc + WIDTH'(PC8_OFS);
        r_validD   <= 1'b1;
      end else begin
        r_validD   <= 1'b0;
      end
    end
  end

  assign InstrD   = r_instrD;
  assign PCPlus8D = r_pcPlus8D;
  assign ValidD   = r_validD;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetchCnt;
  logic [31:0] r_dropCnt;
  logic        w_discard;

  assign w_discard = w_iReq & IAckF &
                     (((r_state == WAIT) & w_redirect) | (r_state == DROP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetchCnt <= '0;
      r_dropCnt  <= '0;
    end else begin
      if (w_load)    r_fetchCnt <= r_fetchCnt + 32'd1;
      if (w_discard) r_dropCnt  <= r_dropCnt + 32'd1;
    end
  end

  assign FetchCntF = r_fetchCnt;
  assign DropCntF  = r_dropCnt;
`else
  assign FetchCntF = '0;
  assign DropCntF  = '0;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the 5-stage ARM pipeline: owns PCF, issues instruction-memory requests over a req/ack handshake, and holds one fetched instruction in a 1-entry fetch buffer (FB).
- Drives the F/D pipeline register (InstrD, PCPlus8D, ValidD).
- Consumes StallF, StallD and FlushD from the hazard unit.
- Applies redirects from BranchTakenE (execute) and PCSrcW (writeback).

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- WIDTH, 32, address and instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- StallF  in  1  hold PCF; no new request issued.
- StallD  in  1  hold F/D register.
- FlushD  in  1  clear F/D register to a bubble.
- BranchTakenE  in  1  redirect to ALUResultE.
- ALUResultE  in  WIDTH  branch target from execute.
- PCSrcW  in  1  redirect to ResultW (PC write in writeback).
- ResultW  in  WIDTH  writeback PC target.
- IReqF  out  1  instruction request valid.
- IAddrF  out  WIDTH  instruction address.
- IAckF  in  1  memory ack; transfer completes on a cycle where IReqF & IAckF; data valid that cycle.
- IRdataF  in  WIDTH  instruction data.
- InstrD  out  WIDTH  decode-stage instruction.
- PCPlus8D  out  WIDTH  fetch PC + 8 (ARM R15 read value).
- ValidD  out  1  InstrD holds a real instruction.
- FetchBusyF  out  1  request outstanding (state != REQ).
- FetchCntF  out  32  accepted-fetch counter (optional feature).
- DropCntF  out  32  discarded-fetch counter (optional feature).

Behaviour:
- Reset (asynchronous, any state, mid-transaction included):
  - PCF = RESET_PC; state = REQ; FB empty.
  - InstrD = 0, PCPlus8D = 0, ValidD = 0; counters = 0.
  - IReqF = 0 while reset is high.
  - Any ack after reset is treated as a fresh transaction.
- Redirect: redirect = BranchTakenE | PCSrcW; target = BranchTakenE ? ALUResultE : ResultW (BranchTakenE wins on a simultaneous redirect). Redirect overrides StallF. On a redirect edge: PCF <= target; FB cleared.
- Request addressing: a request is issued from PCF. The address is latched into ReqAddr at issue. IAddrF = PCF in REQ and ReqAddr in WAIT/DROP; it is stable until ack.
- REQ state:
  - IReqF = ~StallF & ~redirect & (~FB.valid | ~StallD).
  - IReqF & IAckF: FB <= {IRdataF, PCF}; PCF <= PCF+4; stay in REQ. Zero-wait memory gives 1 instr/cycle.
  - IReqF & ~IAckF: go to WAIT.
  - Redirect: stay in REQ with the new PCF.
- WAIT state:
  - IReqF = 1; a request is never withdrawn, StallF is ignored.
  - IAckF & ~redirect: FB load; PCF+4; go to REQ.
  - IAckF & redirect: data discarded; go to REQ.
  - ~IAckF & redirect: go to DROP.
- DROP state:
  - IReqF = 1, IAddrF = ReqAddr.
  - On IAckF: data discarded, PCF unchanged; go to REQ.
  - A further redirect in DROP only updates PCF.
- FB invariant: FB is empty or draining whenever a request is issued, so an ack never overflows FB. Drain and reload may happen on the same edge.
- F/D register, priority FlushD > StallD > load:
  - FlushD: InstrD = 0, PCPlus8D = 0, ValidD = 0.
  - StallD: hold InstrD, PCPlus8D, ValidD.
  - Otherwise, if FB.valid: InstrD = FB.instr, PCPlus8D = FB.pc + 8, ValidD = 1; FB consumed.
  - Otherwise, if FB is empty: ValidD = 0 (bubble).
- FB under flush: FlushD does not clear FB; only a redirect does.
- Latency: with zero-wait memory, an instruction issued in cycle n appears in D at edge n+2.
- Arithmetic: PC+4 and PC+8 are modulo 2^WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - FetchCntF increments on each handshake that loads FB.
  - DropCntF increments on each discarded handshake (redirect in WAIT, or ack in DROP).
  - Both counters wrap at 2^32.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum {REQ, WAIT, DROP}.
  - fb_entry_t struct {valid, instr, pc}.
  - Constants PC_INC = 4, PC8_OFS = 8.
- One sub-module, fetch_buffer: 1-entry FB with load/drain/clear.

Test Plan:
- Reset, zero-wait memory (IAckF=1): IAddrF = 0, 4, 8 on consecutive cycles; InstrD valid from cycle 2; PCPlus8D = 8, 12, 16.
- StallF=StallD=1 for 2 cycles at PCF=0x10: IReqF=0, PCF stays 0x10, InstrD held. On release, fetch resumes at 0x10 with no skipped or duplicated PC.
- 3-cycle ack latency, BranchTakenE=1 with ALUResultE=0x100 in the first WAIT cycle: DROP entered; old ack discarded with DropCntF=1; next IAddrF=0x100.
- BranchTakenE=1 (0x200) and PCSrcW=1 (0x300) in the same cycle: PCF=0x200; FB cleared; the next InstrD comes from 0x200.
- FlushD=1 with StallD=1: ValidD=0 and InstrD=0 next cycle (flush wins). FB retains its entry and delivers it next.
- Assert reset while in WAIT: all outputs go to reset values immediately. After release, IAddrF=RESET_PC and the stale ack does not load FB.
